nios_system_sysid_checker: RTL and testbench
============================================

// Module: nios_system_sysid_checker
// PURPOSE
//  Boot-time sequencer for the system ID slave, acting as an Avalon-MM master on its control_slave.
//  Reads the ID word (address 0) and the timestamp word (address 1), then compares them with build-time expected values.
//  Retries on mismatch or timeout, then reports a sticky pass/fail verdict.
//  Sits beside the Nios II; the verdict gates peripheral enables and drives a status LED.
// PARAMETERS
//  EXPECTED_ID          0           expected word at address 0
//  EXPECTED_TIMESTAMP   1433223846  expected word at address 1
//  CHECK_TIMESTAMP      1           0: skip the address-1 read and compare
//  TIMEOUT_CYCLES       255         waitrequest cycles allowed per read; 0 disables the timeout
//  MAX_RETRIES          3           extra attempts after the first one fails
//  AUTO_START           1           1: begin a check on the first clock after reset release
// PORTS
//  clock            in   1   system clock
//  reset_n          in   1   asynchronous, active-low reset
//  start            in   1   single-cycle request to run a check
//  avm_address      out  1   0 = ID word, 1 = timestamp word
//  avm_read         out  1   read strobe
//  avm_readdata     in   32  slave read data
//  avm_waitrequest  in   1   slave stall
//  busy             out  1   check in progress
//  done             out  1   verdict valid (sticky until the next start)
//  pass             out  1   all compares matched
//  id_error         out  1   last attempt: ID mismatch
//  ts_error         out  1   last attempt: timestamp mismatch
//  timeout_error    out  1   last attempt: read timed out
//  retry_count      out  RW  retries used; RW = $clog2(MAX_RETRIES+1), minimum 1
//  captured_id      out  32  last ID word read
//  captured_ts      out  32  last timestamp word read
// BEHAVIOUR
//  - Reset (asynchronous): all outputs 0, state IDLE. avm_read drops immediately.
//  - States: IDLE, RD_ID, CMP_ID, RD_TS, CMP_TS, RETRY, DONE.
//  - Check launch:
//    - start, or the AUTO_START trigger, is accepted only in IDLE or DONE.
//    - On acceptance: clear done/pass/error flags and retry_count, go to RD_ID.
//    - start while busy is ignored.
//  - RD_x read handshake:
//    - avm_read=1 with avm_address held stable.
//    - The transfer completes on the first cycle with avm_waitrequest=0.
//    - readdata is captured on that edge; avm_read=0 on the next cycle.
//  - Timeout:
//    - A per-read counter increments each cycle in RD_x while waitrequest=1, and clears on entering RD_x.
//    - When the count reaches TIMEOUT_CYCLES: drop avm_read, set timeout_error, go to RETRY.
//  - CMP_ID:
//    - Mismatch: set id_error, go to RETRY.
//    - Match: go to RD_TS, or to DONE with pass=1 when CHECK_TIMESTAMP=0.
//  - CMP_TS:
//    - Mismatch: set ts_error, go to RETRY.
//    - Match: go to DONE with pass=1.
//  - RETRY (one idle cycle):
//    - retry_count == MAX_RETRIES: go to DONE with pass=0.
//    - Otherwise: retry_count++, clear the error flags, go to RD_ID.
//    - Error flags and captured_* always reflect the final attempt.
//  - DONE: done=1, busy=0, flags held.
//  - Zero-wait latency: start sampled at edge N gives avm_read=1 in cycle N+1 and done=1 at N+5 (N+3 when CHECK_TIMESTAMP=0).
//    Each waitrequest cycle adds 1.
//  - Boundary cases:
//    - MAX_RETRIES=0: single attempt.
//    - TIMEOUT_CYCLES=0: wait indefinitely.
//    - Timeout and data return in the same cycle: the data wins.
// STRUCTURE
//  - Package nios_system_sysid_pkg holds:
//    - state enum
//    - SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1
//    - SYSID_DATA_W=32
//  - One sub-module, nios_system_sysid_rd_timer: a parameterised timeout counter with clear/enable/expired.
//    Instantiated once and shared by both read states.
// TESTING
//  1. Slave model with waitrequest=0 returning 0 / 1433223846; pulse start.
//     -> done at N+5, pass=1, all errors 0, retry_count=0, captured_ts=1433223846.
//  2. Slave model returns timestamp 0x12345678.
//     -> 4 attempts, then done=1, pass=0, ts_error=1, retry_count=3, captured_ts=0x12345678.
//  3. waitrequest stuck high.
//     -> each read drops after 255 cycles; final timeout_error=1, pass=0, retry_count=3, busy low afterwards.
//  4. waitrequest high for 3 cycles per read.
//     -> address/read stable while stalled, pass=1, done at N+11.
//  5. reset_n low during RD_TS.
//     -> avm_read and all outputs 0 asynchronously. After release with AUTO_START=1, the check reruns and pass=1.
//  6. start pulsed while busy.
//     -> ignored, no restart. start in DONE after a failure -> flags cleared next cycle, rerun passes.

Source files
------------

// File: rtl/nios_system_sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Holds the sequencer state encoding, the slave word map and the counter-width helper.
package nios_system_sysid_pkg;

    localparam int   SYSID_DATA_W  = 32;
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        CMP_ID,
        RD_TS,
        CMP_TS,
        RETRY,
        DONE
    } sysid_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int sysid_cnt_w(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/nios_system_sysid_rd_timer.sv
// Per-read stall counter: expired is combinational in the cycle that would be the last allowed stall.
// No backpressure of its own; clear restarts the count, TIMEOUT_CYCLES=0 never expires.
module nios_system_sysid_rd_timer
    import nios_system_sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = sysid_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Boot-time Avalon-MM master that reads and verifies the system ID and timestamp words, with retries.
// Zero-wait check: start at edge N -> done after edge N+4; each waitrequest cycle stalls the sequence by one.
module nios_system_sysid_checker
    import nios_system_sysid_pkg::*;
#(
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1433223846,
    parameter bit                      CHECK_TIMESTAMP    = 1'b1,
    parameter int                      TIMEOUT_CYCLES     = 255,
    parameter int                      MAX_RETRIES        = 3,
    parameter bit                      AUTO_START         = 1'b1,
    localparam int                     RW                 = sysid_cnt_w(MAX_RETRIES)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    avm_address,
    output logic                    avm_read,
    input  logic [SYSID_DATA_W-1:0] avm_readdata,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    id_error,
    output logic                    ts_error,
    output logic                    timeout_error,
    output logic [RW-1:0]           retry_count,
    output logic [SYSID_DATA_W-1:0] captured_id,
    output logic [SYSID_DATA_W-1:0] captured_ts
);

    sysid_state_t state, state_nxt;
    logic         auto_pending;
    logic         trigger;
    logic         in_rd;
    logic         tmo_expired;
    logic         id_match;
    logic         ts_match;
    logic         retries_left;

    assign trigger      = start || auto_pending;
    assign in_rd        = (state == RD_ID) || (state == RD_TS);
    assign id_match     = (captured_id == EXPECTED_ID);
    assign ts_match     = (captured_ts == EXPECTED_TIMESTAMP);
    assign retries_left = (retry_count != RW'(MAX_RETRIES));

    // One timer serves both reads; it restarts whenever the FSM is outside a read state.
    nios_system_sysid_rd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!in_rd),
        .enable  (in_rd && avm_waitrequest),
        .expired (tmo_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        avm_read    = 1'b0;
        avm_address = SYSID_ADDR_ID;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trigger) state_nxt = RD_ID;
            end
            RD_ID: begin
                avm_read = 1'b1;
                if (!avm_waitrequest)  state_nxt = CMP_ID;
                else if (tmo_expired)  state_nxt = RETRY;
            end
            CMP_ID: begin
                if (!id_match)             state_nxt = RETRY;
                else if (CHECK_TIMESTAMP)  state_nxt = RD_TS;
                else                       state_nxt = DONE;
            end
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = SYSID_ADDR_TS;
                if (!avm_waitrequest)  state_nxt = CMP_TS;
                else if (tmo_expired)  state_nxt = RETRY;
            end
            CMP_TS: begin
                state_nxt = ts_match ? DONE : RETRY;
            end
            RETRY: begin
                state_nxt = retries_left ? RD_ID : DONE;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (trigger) state_nxt = RD_ID;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Verdict flags and captured words; the last attempt's values survive into DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pending  <= AUTO_START;
            pass          <= 1'b0;
            id_error      <= 1'b0;
            ts_error      <= 1'b0;
            timeout_error <= 1'b0;
            retry_count   <= '0;
            captured_id   <= '0;
            captured_ts   <= '0;
        end else begin
            auto_pending <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (trigger) begin
                        pass          <= 1'b0;
                        id_error      <= 1'b0;
                        ts_error      <= 1'b0;
                        timeout_error <= 1'b0;
                        retry_count   <= '0;
                    end
                end
                RD_ID: begin
                    if (!avm_waitrequest)  captured_id   <= avm_readdata;
                    else if (tmo_expired)  timeout_error <= 1'b1;
                end
                RD_TS: begin
                    if (!avm_waitrequest)  captured_ts   <= avm_readdata;
                    else if (tmo_expired)  timeout_error <= 1'b1;
                end
                CMP_ID: begin
                    if (!id_match)              id_error <= 1'b1;
                    else if (!CHECK_TIMESTAMP)  pass     <= 1'b1;
                end
                CMP_TS: begin
                    if (!ts_match)  ts_error <= 1'b1;
                    else            pass     <= 1'b1;
                end
                RETRY: begin
                    if (retries_left) begin
                        retry_count   <= retry_count + RW'(1);
                        id_error      <= 1'b0;
                        ts_error      <= 1'b0;
                        timeout_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench for the system-ID checker: an Avalon slave model with programmable stalls and data.
module tb_nios_system_sysid_checker;

    localparam logic [31:0] GOOD_TS = 32'd1433223846;
    localparam logic [31:0] BAD_TS  = 32'h1234_5678;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_error, ts_error, timeout_error;
    logic [1:0]  retry_count;
    logic [31:0] captured_id, captured_ts;

    logic [31:0] id_val    = 32'd0;
    logic [31:0] ts_val    = GOOD_TS;
    int          stall_cfg = 0;
    logic        stuck     = 1'b0;
    int          stall_cnt = 0;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   id_starts = 0, ts_starts = 0, run_len = 0, last_run = 0, addr_viol = 0;
    logic prev_read = 1'b0, prev_stall = 1'b0, prev_addr = 1'b0;

    nios_system_sysid_checker dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_error        (id_error),
        .ts_error        (ts_error),
        .timeout_error   (timeout_error),
        .retry_count     (retry_count),
        .captured_id     (captured_id),
        .captured_ts     (captured_ts)
    );

    always #5 clock = ~clock;

    assign avm_waitrequest = avm_read && (stuck || (stall_cnt < stall_cfg));
    assign avm_readdata    = avm_address ? ts_val : id_val;

    // Slave stall counter plus bus monitors (read starts, read-strobe run length, stall stability).
    always @(posedge clock) begin
        stall_cnt  <= (avm_read && avm_waitrequest) ? stall_cnt + 1 : 0;
        prev_read  <= avm_read;
        prev_stall <= avm_read && avm_waitrequest;
        prev_addr  <= avm_address;
        if (avm_read && !prev_read && !avm_address) id_starts <= id_starts + 1;
        if (avm_read && !prev_read &&  avm_address) ts_starts <= ts_starts + 1;
        if (prev_stall && !(avm_read && (avm_address == prev_addr))) addr_viol <= addr_viol + 1;
        if (avm_read) run_len <= run_len + 1;
        else if (run_len != 0) begin
            last_run <= run_len;
            run_len  <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the edge that sampled start.
    task automatic pulse_start;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (!done && edges < budget) begin
            @(posedge clock);
            #1;
            edges++;
        end
        check_eq("done_seen", {31'b0, done}, 32'd1);
    endtask

    initial begin
        int   edges;
        int   s_id, s_ts, s_viol;
        logic found;

        // Reset state
        reset_n = 1'b0;
        #12;
        check_eq("rst_flags", {22'b0, busy, done, pass, id_error, ts_error, timeout_error,
                               avm_read, avm_address, retry_count}, 32'd0);
        check_eq("rst_cap_id", captured_id, 32'd0);
        check_eq("rst_cap_ts", captured_ts, 32'd0);

        // Auto-start on the first edge after release
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_eq("auto_read", {31'b0, avm_read}, 32'd1);
        wait_done(50, edges);
        check_eq("auto_pass", {31'b0, pass}, 32'd1);

        // 1: zero-wait check, done 4 edges after the start edge (cycle N+5)
        pulse_start();
        check_eq("t1_read_addr", {30'b0, avm_read, avm_address}, 32'h2);
        wait_done(50, edges);
        check_eq("t1_latency", edges, 32'd4);
        check_eq("t1_pass", {31'b0, pass}, 32'd1);
        check_eq("t1_errors", {29'b0, id_error, ts_error, timeout_error}, 32'd0);
        check_eq("t1_retry", {30'b0, retry_count}, 32'd0);
        check_eq("t1_cap_id", captured_id, 32'd0);
        check_eq("t1_cap_ts", captured_ts, GOOD_TS);

        // ID mismatch: four attempts, no timestamp read at all
        id_val = 32'd5;
        s_id = id_starts;
        s_ts = ts_starts;
        pulse_start();
        wait_done(100, edges);
        check_eq("id_pass", {31'b0, pass}, 32'd0);
        check_eq("id_errors", {29'b0, id_error, ts_error, timeout_error}, 32'h4);
        check_eq("id_retry", {30'b0, retry_count}, 32'd3);
        check_eq("id_cap", captured_id, 32'd5);
        check_eq("id_attempts", id_starts - s_id, 32'd4);
        check_eq("id_no_ts_reads", ts_starts - s_ts, 32'd0);
        id_val = 32'd0;

        // 2: wrong timestamp
        ts_val = BAD_TS;
        s_id = id_starts;
        pulse_start();
        wait_done(100, edges);
        check_eq("t2_pass", {31'b0, pass}, 32'd0);
        check_eq("t2_errors", {29'b0, id_error, ts_error, timeout_error}, 32'h2);
        check_eq("t2_retry", {30'b0, retry_count}, 32'd3);
        check_eq("t2_cap_ts", captured_ts, BAD_TS);
        check_eq("t2_attempts", id_starts - s_id, 32'd4);
        ts_val = GOOD_TS;

        // 3: waitrequest stuck high, each read strobe lasts 255 cycles
        stuck = 1'b1;
        s_id = id_starts;
        pulse_start();
        wait_done(3000, edges);
        check_eq("t3_errors", {29'b0, id_error, ts_error, timeout_error}, 32'h1);
        check_eq("t3_pass", {31'b0, pass}, 32'd0);
        check_eq("t3_retry", {30'b0, retry_count}, 32'd3);
        check_eq("t3_busy", {31'b0, busy}, 32'd0);
        check_eq("t3_read_len", last_run, 32'd255);
        check_eq("t3_attempts", id_starts - s_id, 32'd4);
        stuck = 1'b0;

        // 4: three stall cycles per read -> 4 + 2*3 edges
        stall_cfg = 3;
        s_viol = addr_viol;
        pulse_start();
        wait_done(100, edges);
        check_eq("t4_latency", edges, 32'd10);
        check_eq("t4_pass", {31'b0, pass}, 32'd1);
        check_eq("t4_stable", addr_viol - s_viol, 32'd0);
        check_eq("t4_ts_read_len", last_run, 32'd4);

        // 5: asynchronous reset while the timestamp read is stalled
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (avm_read && avm_address) found = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        check_eq("t5_in_rd_ts", {31'b0, found}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_flags", {22'b0, busy, done, pass, id_error, ts_error, timeout_error,
                                  avm_read, avm_address, retry_count}, 32'd0);
        check_eq("t5_rst_cap_ts", captured_ts, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(100, edges);
        check_eq("t5_rerun_pass", {31'b0, pass}, 32'd1);
        check_eq("t5_rerun_ts", captured_ts, GOOD_TS);

        // 6: start while busy is ignored; start in DONE after a failure clears flags
        stall_cfg = 0;
        s_id = id_starts;
        pulse_start();
        pulse_start();
        wait_done(50, edges);
        check_eq("t6_no_restart_lat", edges, 32'd3);
        check_eq("t6_single_attempt", id_starts - s_id, 32'd1);
        check_eq("t6_pass", {31'b0, pass}, 32'd1);
        ts_val = BAD_TS;
        pulse_start();
        wait_done(100, edges);
        check_eq("t6_fail", {31'b0, pass}, 32'd0);
        ts_val = GOOD_TS;
        pulse_start();
        check_eq("t6_cleared", {26'b0, busy, done, pass, id_error, ts_error, timeout_error}, 32'h20);
        check_eq("t6_cleared_retry", {30'b0, retry_count}, 32'd0);
        wait_done(50, edges);
        check_eq("t6_rerun_pass", {31'b0, pass}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
